// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter and its busy scoreboard.
// Default widths here are also the defaults of the top-level parameters.
package rf_arb_pkg;

   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 3;
   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } rf_wr_req_t;

   typedef logic [NUM_REGS-1:0] rf_busy_t;

   function automatic int wrap_inc(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// One-hot grant among NUM_REQ requests, zero latency; the pointer advances past the winner on accept.
// RF_ARB_FIXED_PRIO_EN selects lowest-index-wins with no pointer state.
module rr_arbiter
   import rf_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               accept,
   output logic [NUM_REQ-1:0] gnt
);

`ifdef RF_ARB_FIXED_PRIO_EN
   logic unused_ok;
   assign unused_ok = ^{clk, rst_n, accept};

   always_comb begin
      gnt = req & (~req + NUM_REQ'(1));
   end
`else
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [2*NUM_REQ-1:0] dbl_req, dbl_gnt;
   logic [NUM_REQ-1:0]   rot_req, rot_gnt;

   // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
   always_comb begin
      dbl_req = {req, req} >> ptr_q;
      rot_req = dbl_req[NUM_REQ-1:0];
      rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
      dbl_gnt = {rot_gnt, rot_gnt} << ptr_q;
      gnt     = dbl_gnt[2*NUM_REQ-1:NUM_REQ];
   end

   always_comb begin
      ptr_d = ptr_q;
      if (accept) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) ptr_d = PTR_W'(wrap_inc(i, NUM_REQ));
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end
`endif

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the RF write port among NUM_REQ requesters (grant same cycle, write one cycle later) and
// keeps the per-register busy scoreboard; non-winners are held off by req_ready. Macro: RF_ARB_FIXED_PRIO_EN.
module rf_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = rf_arb_pkg::ADDR_W,
   parameter int DATA_W  = rf_arb_pkg::DATA_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_addr,
   output logic                      rf_write_en,
   output logic [ADDR_W-1:0]         rf_write_addr,
   output logic [DATA_W-1:0]         rf_write_data,
   output logic [2**ADDR_W-1:0]      busy,
   output logic                      err_waw
);

   localparam int NUM_REGS = 2 ** ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_req_t;

   logic [NUM_REQ-1:0]  gnt;
   logic                xfer;
   wr_req_t             win;
   wr_req_t             wr_q, wr_d;
   logic                wr_en_q, wr_en_d;
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic                err_waw_q, err_waw_d;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req_valid),
      .accept (xfer),
      .gnt    (gnt)
   );

   assign req_ready = gnt & {NUM_REQ{rst_n}};
   assign xfer      = |(req_valid & req_ready);

   always_comb begin
      win = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            win.addr = req_addr[i*ADDR_W +: ADDR_W];
            win.data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Set is applied after clear so a new producer wins over the retiring one.
   always_comb begin
      wr_en_d = xfer;
      wr_d    = xfer ? win : wr_q;
      busy_d  = busy_q;
      if (wr_en_q)     busy_d[wr_q.addr]  = 1'b0;
      if (issue_valid) busy_d[issue_addr] = 1'b1;
      err_waw_d = err_waw_q |
                  (issue_valid & busy_q[issue_addr] & ~(wr_en_q & (wr_q.addr == issue_addr)));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_q   <= 1'b0;
         wr_q      <= '0;
         busy_q    <= '0;
         err_waw_q <= 1'b0;
      end else begin
         wr_en_q   <= wr_en_d;
         wr_q      <= wr_d;
         busy_q    <= busy_d;
         err_waw_q <= err_waw_d;
      end
   end

   assign rf_write_en   = wr_en_q;
   assign rf_write_addr = wr_q.addr;
   assign rf_write_data = wr_q.data;
   assign busy          = busy_q;
   assign err_waw       = err_waw_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed cycle table, reset sequence, then random traffic vs a reference model.
module tb_rf_write_arbiter;

   localparam int N  = 2;
   localparam int AW = 3;
   localparam int DW = 3;
   localparam int NR = 8;
`ifdef RF_ARB_FIXED_PRIO_EN
   localparam bit FP = 1'b1;
`else
   localparam bit FP = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            issue_valid;
   logic [AW-1:0]   issue_addr;
   logic            rf_write_en;
   logic [AW-1:0]   rf_write_addr;
   logic [DW-1:0]   rf_write_data;
   logic [NR-1:0]   busy;
   logic            err_waw;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .issue_valid   (issue_valid),
      .issue_addr    (issue_addr),
      .rf_write_en   (rf_write_en),
      .rf_write_addr (rf_write_addr),
      .rf_write_data (rf_write_data),
      .busy          (busy),
      .err_waw       (err_waw)
   );

   typedef struct {
      logic [N-1:0]  v;
      logic [AW-1:0] a0, a1;
      logic [DW-1:0] d0, d1;
      logic          iv;
      logic [AW-1:0] ia;
      logic [N-1:0]  rdy;
      logic          en;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic [NR-1:0] bsy;
      logic          err;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mk(input int v, a0, d0, a1, d1, iv, ia,
                               input int rdy, en, wa, wd, bsy, err);
      vec_t r;
      r.v = N'(v);   r.a0 = AW'(a0); r.d0 = DW'(d0); r.a1 = AW'(a1); r.d1 = DW'(d1);
      r.iv = 1'(iv); r.ia = AW'(ia);
      r.rdy = N'(rdy); r.en = 1'(en); r.wa = AW'(wa); r.wd = DW'(wd);
      r.bsy = NR'(bsy); r.err = 1'(err);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_outs(input string tag, input logic en, input logic [AW-1:0] wa,
                           input logic [DW-1:0] wd, input logic [NR-1:0] bsy, input logic err);
      chk({tag, " en"},   32'(rf_write_en),   32'(en));
      chk({tag, " addr"}, 32'(rf_write_addr), 32'(wa));
      chk({tag, " data"}, 32'(rf_write_data), 32'(wd));
      chk({tag, " busy"}, 32'(busy),          32'(bsy));
      chk({tag, " err"},  32'(err_waw),       32'(err));
   endtask

   task automatic do_reset();
      req_valid = '0; req_addr = '0; req_data = '0; issue_valid = 1'b0; issue_addr = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   // Reference model state
   int            m_ptr, w;
   bit [NR-1:0]   m_busy, nb;
   bit            m_err, m_en;
   bit [AW-1:0]   m_wa;
   bit [DW-1:0]   m_wd;
   bit [N-1:0]    hold, exp_rdy;
   bit [AW-1:0]   h_a[N];
   bit [DW-1:0]   h_d[N];

   initial begin
      // Contention rows: requester 1 wins first under round-robin (ptr=1 after the single write).
      tbl[0]  = mk(0,0,0,0,0, 1,5, 0, 0,0,0, 'h20,0);
      tbl[1]  = mk(1,5,3,0,0, 0,0, 1, 1,5,3, 'h20,0);
      tbl[2]  = mk(0,0,0,0,0, 0,0, 0, 0,5,3, 'h00,0);
      tbl[3]  = mk(3,1,1,2,2, 0,0, FP?1:2, 1,FP?1:2,FP?1:2, 0,0);
      tbl[4]  = mk(3,1,1,2,2, 0,0, 1, 1,1,1, 0,0);
      tbl[5]  = mk(3,1,1,2,2, 0,0, FP?1:2, 1,FP?1:2,FP?1:2, 0,0);
      tbl[6]  = mk(3,1,1,2,2, 0,0, 1, 1,1,1, 0,0);
      tbl[7]  = mk(3,1,1,2,2, 0,0, FP?1:2, 1,FP?1:2,FP?1:2, 0,0);
      tbl[8]  = mk(3,1,1,2,2, 0,0, 1, 1,1,1, 0,0);
      tbl[9]  = mk(0,0,0,0,0, 1,2, 0, 0,1,1, 'h04,0);
      tbl[10] = mk(1,2,6,0,0, 0,0, 1, 1,2,6, 'h04,0);
      tbl[11] = mk(0,0,0,0,0, 1,2, 0, 0,2,6, 'h04,0);
      tbl[12] = mk(0,0,0,0,0, 0,0, 0, 0,2,6, 'h04,0);
      tbl[13] = mk(2,0,0,7,1, 0,0, 2, 1,7,1, 'h04,0);
      tbl[14] = mk(2,0,0,7,2, 0,0, 2, 1,7,2, 'h04,0);
      tbl[15] = mk(2,0,0,7,3, 0,0, 2, 1,7,3, 'h04,0);
      tbl[16] = mk(2,0,0,7,4, 0,0, 2, 1,7,4, 'h04,0);
      tbl[17] = mk(0,0,0,0,0, 0,0, 0, 0,7,4, 'h04,0);
      tbl[18] = mk(0,0,0,0,0, 1,4, 0, 0,7,4, 'h14,0);
      tbl[19] = mk(0,0,0,0,0, 1,4, 0, 0,7,4, 'h14,1);
      tbl[20] = mk(1,4,5,0,0, 0,0, 1, 1,4,5, 'h14,1);
      tbl[21] = mk(0,0,0,0,0, 0,0, 0, 0,4,5, 'h04,1);

      req_valid = '0; req_addr = '0; req_data = '0; issue_valid = 1'b0; issue_addr = '0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk_outs("reset", 1'b0, '0, '0, '0, 1'b0);
      chk("reset rdy", 32'(req_ready), 32'(0));
      rst_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         req_valid = tbl[i].v;
         req_addr  = {tbl[i].a1, tbl[i].a0};
         req_data  = {tbl[i].d1, tbl[i].d0};
         issue_valid = tbl[i].iv;
         issue_addr  = tbl[i].ia;
         #1;
         chk($sformatf("vec%0d rdy", i), 32'(req_ready), 32'(tbl[i].rdy));
         @(posedge clk); #1;
         chk_outs($sformatf("vec%0d", i), tbl[i].en, tbl[i].wa, tbl[i].wd, tbl[i].bsy, tbl[i].err);
      end

      // Asynchronous reset while a write is on the port.
      req_valid = 2'b01; req_addr = {3'd0, 3'd3}; req_data = {3'd0, 3'd2};
      issue_valid = 1'b1; issue_addr = 3'd6;
      @(posedge clk); #1;
      chk("pre-reset en", 32'(rf_write_en), 32'(1));
      issue_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk_outs("async reset", 1'b0, '0, '0, '0, 1'b0);
      chk("rdy in reset", 32'(req_ready), 32'(0));
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("post-reset rdy idle", 32'(req_ready), 32'(0));
      req_valid = 2'b11;
      #1;
      chk("post-reset ptr", 32'(req_ready), 32'(1));
      @(posedge clk); #1;
      chk_outs("post-reset write", 1'b1, 3'd3, 3'd2, '0, 1'b0);
      req_valid = '0;

      // Random traffic against the reference model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 300 == 0) begin
            do_reset();
            m_ptr = 0; m_busy = '0; m_err = 0; m_en = 0; m_wa = '0; m_wd = '0; hold = '0;
         end
         for (int i = 0; i < N; i++) begin
            if (!hold[i] && $urandom_range(0, 2) == 0) begin
               hold[i] = 1'b1;
               h_a[i]  = AW'($urandom_range(0, NR-1));
               h_d[i]  = DW'($urandom);
            end
            req_addr[i*AW +: AW] = h_a[i];
            req_data[i*DW +: DW] = h_d[i];
         end
         req_valid   = hold;
         issue_valid = ($urandom_range(0, 5) == 0);
         issue_addr  = AW'($urandom_range(0, NR-1));

         w = -1;
         for (int k = 0; k < N; k++) begin
            if (w < 0 && hold[FP ? k : (m_ptr + k) % N]) w = FP ? k : (m_ptr + k) % N;
         end
         exp_rdy = (w >= 0) ? (N'(1) << w) : '0;
         #1;
         chk($sformatf("rand%0d rdy", cyc), 32'(req_ready), 32'(exp_rdy));

         nb = m_busy;
         if (m_en) nb[m_wa] = 1'b0;
         if (issue_valid) begin
            if (m_busy[issue_addr] && !(m_en && m_wa == issue_addr)) m_err = 1'b1;
            nb[issue_addr] = 1'b1;
         end
         m_busy = nb;
         m_en = (w >= 0);
         if (w >= 0) begin
            m_wa = h_a[w];
            m_wd = h_d[w];
            hold[w] = 1'b0;
            m_ptr = (w + 1) % N;
         end

         @(posedge clk); #1;
         chk_outs($sformatf("rand%0d", cyc), m_en, m_wa, m_wd, m_busy, m_err);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
